// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : key_pkg
//  Description : Shared constants, FSM state encoding and helper functions
//                for the key/switch input blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

  localparam int              NUM_KEYS      = 8;
  localparam int              CODE_W        = 3;
  localparam logic [NUM_KEYS-1:0] KEYS_RELEASED = 8'hFF;

  // Debounce FSM state encoding
  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_debounce = 2'd1;
  localparam logic [1:0] c_pressed  = 2'd2;
  localparam logic [1:0] c_release  = 2'd3;

  // Index of the highest set bit; bit 7 wins. Callers only pass v != 0.
  function automatic logic [CODE_W-1:0] prio_enc8(input logic [NUM_KEYS-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) r = CODE_W'(i);
    end
    return r;
  endfunction

  // True when more than one bit of v is set.
  function automatic logic multi_hot8(input logic [NUM_KEYS-1:0] v);
    return (v & (v - 8'd1)) != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Generic two-flop synchroniser with a parameterised reset
//                value, for bringing asynchronous inputs into clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops; the first may go metastable, the second settles it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/encode83_key.sv
`default_nettype none
// ============================================================================
//  Module      : encode83_key
//  Description : Debounced 8-to-3 priority encoder for active-low push keys.
//                Synchronises the key lines, debounces the whole vector and
//                reports the highest pressed key with a one-cycle strobe.
//                Optional auto-repeat while held: define KEY_REPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module encode83_key
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int REPEAT_CYCLES   = 6000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [CODE_W-1:0]   code,
  output logic                code_valid,
  output logic                key_held,
  output logic                multi
);

  localparam int              CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] w_key_sync;
  logic [NUM_KEYS-1:0] w_active;
  logic                w_rep_fire;

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_KEYS-1:0] r_snap;
  logic [CODE_W-1:0]   r_code;
  logic                r_code_valid;
  logic                r_key_held;
  logic                r_multi;

  sync2 #(
    .WIDTH     (NUM_KEYS),
    .RESET_VAL (KEYS_RELEASED)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_n),
    .q   (w_key_sync)
  );

  assign w_active = ~w_key_sync;

`ifdef KEY_REPEAT_EN
  localparam int               REP_W     = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] c_rep_max = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] r_rep_cnt;

  assign w_rep_fire = (r_state == c_pressed) && (w_active != '0) &&
                      (r_rep_cnt == c_rep_max);

  // Repeat timer runs only while a key is down in PRESSED; zero everywhere else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_cnt <= '0;
    end else if ((r_state == c_pressed) && (w_active != '0)) begin
      r_rep_cnt <= w_rep_fire ? '0 : r_rep_cnt + 1'b1;
    end else begin
      r_rep_cnt <= '0;
    end
  end
`else
  // No auto-repeat: exactly one strobe per accepted press. REPEAT_CYCLES is
  // referenced so both builds share an identical parameter interface.
  assign w_rep_fire = 1'b0 & (REPEAT_CYCLES != 0);
`endif

  // Debounce FSM: accept a press/release only after the vector is stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_idle;
      r_cnt        <= '0;
      r_snap       <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_key_held   <= 1'b0;
      r_multi      <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_active != '0) begin
            r_state <= c_debounce;
            r_cnt   <= '0;
            r_snap  <= w_active;
          end
        end
        c_debounce: begin
          if (w_active == '0) begin
            r_state <= c_idle;
            r_cnt   <= '0;
          end else if (w_active != r_snap) begin
            // Vector changed: restart the stability window on the new value
            r_snap <= w_active;
            r_cnt  <= '0;
          end else if (r_cnt == c_cnt_max) begin
            r_state      <= c_pressed;
            r_cnt        <= '0;
            r_code       <= prio_enc8(r_snap);
            r_multi      <= multi_hot8(r_snap);
            r_code_valid <= 1'b1;
            r_key_held   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_pressed: begin
          if (w_active == '0) begin
            r_state <= c_release;
            r_cnt   <= '0;
          end else if (w_rep_fire) begin
            r_code       <= prio_enc8(w_active);
            r_multi      <= multi_hot8(w_active);
            r_code_valid <= 1'b1;
          end
        end
        c_release: begin
          if (w_active != '0) begin
            // Contact bounce on release: back to held, silently
            r_state <= c_pressed;
            r_cnt   <= '0;
          end else if (r_cnt == c_cnt_max) begin
            r_state    <= c_idle;
            r_cnt      <= '0;
            r_key_held <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= c_idle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign key_held   = r_key_held;
  assign multi      = r_multi;

endmodule
`default_nettype wire
